// File: rtl/mem_writeback_result_queue.sv
// rtl/mem_writeback_result_queue.sv - in-order result queue feeding one writeback mux port
// Optional sticky protocol error detection: define WB_QUEUE_ERRFLAG_EN.
module mem_writeback_result_queue #(
    parameter int DATABITWIDTH    = 16,
    parameter int TAGBITWIDTH     = 6,
    parameter int REGADDRBITWIDTH = 4,
    parameter int DEPTH           = 4,
    parameter int PTRBITWIDTH     = 2
) (
    input  logic                       clk,
    input  logic                       async_rst_n,
    input  logic                       clk_en,
    input  logic                       Flush,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [DATABITWIDTH-1:0]    InData,
    input  logic [TAGBITWIDTH-1:0]     InTag,
    input  logic [REGADDRBITWIDTH-1:0] InAddr,
    output logic                       WritebackACK,
    input  logic                       WritebackREQ,
    output logic [DATABITWIDTH-1:0]    WritebackDataOut,
    output logic [TAGBITWIDTH-1:0]     WritebackTagOut,
    output logic [REGADDRBITWIDTH-1:0] WritebackAddrOut,
    output logic [PTRBITWIDTH:0]       Occupancy,
    output logic                       ErrorFlag
);

    logic [DATABITWIDTH-1:0]    data_mem [DEPTH];
    logic [TAGBITWIDTH-1:0]     tag_mem  [DEPTH];
    logic [REGADDRBITWIDTH-1:0] addr_mem [DEPTH];

    logic [PTRBITWIDTH:0]   wr_ptr;
    logic [PTRBITWIDTH:0]   rd_ptr;
    logic [PTRBITWIDTH-1:0] wr_idx;
    logic [PTRBITWIDTH-1:0] rd_idx;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign wr_idx = wr_ptr[PTRBITWIDTH-1:0];
    assign rd_idx = rd_ptr[PTRBITWIDTH-1:0];

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr[PTRBITWIDTH] != rd_ptr[PTRBITWIDTH]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);

    assign InReady      = !full;
    assign WritebackACK = !empty;
    assign Occupancy    = wr_ptr - rd_ptr;

    assign push = clk_en && InValid && !full && !Flush;
    assign pop  = clk_en && WritebackREQ && !empty && !Flush;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clk_en) begin
            if (Flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_idx] <= InData;
            tag_mem[wr_idx]  <= InTag;
            addr_mem[wr_idx] <= InAddr;
        end
    end

    assign WritebackDataOut = empty ? '0 : data_mem[rd_idx];
    assign WritebackTagOut  = empty ? '0 : tag_mem[rd_idx];
    assign WritebackAddrOut = empty ? '0 : addr_mem[rd_idx];

`ifdef WB_QUEUE_ERRFLAG_EN
    logic error_event;

    assign error_event = (clk_en && WritebackREQ && empty) ||
                         (clk_en && InValid && full && Flush);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            ErrorFlag <= 1'b0;
        end else if (error_event) begin
            ErrorFlag <= 1'b1;
        end
    end
`else
    assign ErrorFlag = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writeback_result_queue.sv
// tb/tb_mem_writeback_result_queue.sv - directed bench for mem_writeback_result_queue
module tb_mem_writeback_result_queue;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [15:0] InData;
    logic [5:0]  InTag;
    logic [3:0]  InAddr;
    logic        WritebackACK;
    logic        WritebackREQ;
    logic [15:0] WritebackDataOut;
    logic [5:0]  WritebackTagOut;
    logic [3:0]  WritebackAddrOut;
    logic [2:0]  Occupancy;
    logic        ErrorFlag;

    int checks   = 0;
    int failures = 0;

`ifdef WB_QUEUE_ERRFLAG_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_writeback_result_queue dut (
        .clk              (clk),
        .async_rst_n      (async_rst_n),
        .clk_en           (clk_en),
        .Flush            (Flush),
        .InValid          (InValid),
        .InReady          (InReady),
        .InData           (InData),
        .InTag            (InTag),
        .InAddr           (InAddr),
        .WritebackACK     (WritebackACK),
        .WritebackREQ     (WritebackREQ),
        .WritebackDataOut (WritebackDataOut),
        .WritebackTagOut  (WritebackTagOut),
        .WritebackAddrOut (WritebackAddrOut),
        .Occupancy        (Occupancy),
        .ErrorFlag        (ErrorFlag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] d, input logic [5:0] t, input logic [3:0] a);
        InValid = v;
        InData  = d;
        InTag   = t;
        InAddr  = a;
    endtask

    task automatic chk_head(input string tag, input logic ack, input logic [15:0] d,
                            input logic [5:0] t, input logic [3:0] a, input logic [2:0] occ);
        chk({tag, "_ack"},  WritebackACK,     ack);
        chk({tag, "_data"}, WritebackDataOut, d);
        chk({tag, "_tag"},  WritebackTagOut,  t);
        chk({tag, "_addr"}, WritebackAddrOut, a);
        chk({tag, "_occ"},  Occupancy,        occ);
    endtask

    initial begin
        async_rst_n  = 1'b0;
        clk_en       = 1'b1;
        Flush        = 1'b0;
        WritebackREQ = 1'b0;
        set_in(1'b0, 16'h0, 6'h0, 4'h0);
        step();
        chk_head("reset", 1'b0, 16'h0, 6'h0, 4'h0, 3'd0);
        chk("reset_ready", InReady, 1'b1);
        chk("reset_err", ErrorFlag, 1'b0);
        async_rst_n = 1'b1;
        step();

        // single push: visible right after the push edge
        set_in(1'b1, 16'h1234, 6'd5, 4'd3);
        step();
        set_in(1'b0, 16'h0, 6'h0, 4'h0);
        chk_head("push1", 1'b1, 16'h1234, 6'd5, 4'd3, 3'd1);
        chk("push1_ready", InReady, 1'b1);

        // fill to full
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 16'h1111 * i[15:0], i[5:0], i[3:0]);
            step();
        end
        set_in(1'b1, 16'h9999, 6'd9, 4'd9);
        chk("full_ready", InReady, 1'b0);
        chk("full_occ", Occupancy, 3'd4);
        step();
        step();
        chk_head("full_hold", 1'b1, 16'h1234, 6'd5, 4'd3, 3'd4);
        chk("full_hold_ready", InReady, 1'b0);

        // drain in push order
        set_in(1'b0, 16'h0, 6'h0, 4'h0);
        WritebackREQ = 1'b1;
        step();
        chk_head("pop1", 1'b1, 16'h1111, 6'd1, 4'd1, 3'd3);
        chk("pop1_ready", InReady, 1'b1);
        step();
        chk_head("pop2", 1'b1, 16'h2222, 6'd2, 4'd2, 3'd2);
        step();
        chk_head("pop3", 1'b1, 16'h3333, 6'd3, 4'd3, 3'd1);
        step();
        WritebackREQ = 1'b0;
        chk_head("pop4", 1'b0, 16'h0, 6'h0, 4'h0, 3'd0);
        chk("pop4_err", ErrorFlag, 1'b0);

        // simultaneous push+pop at occupancy 2, wrapping pointers
        set_in(1'b1, 16'h00A0, 6'h20, 4'h0);
        step();
        set_in(1'b1, 16'h00A1, 6'h21, 4'h1);
        step();
        chk("pp_pre_occ", Occupancy, 3'd2);
        WritebackREQ = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            set_in(1'b1, 16'h00B0 + 16'(k - 1), 6'h30 + 6'(k - 1), 4'(k - 1));
            step();
            chk("pp_data", WritebackDataOut, (k == 1) ? 16'h00A1 : 16'h00B0 + 16'(k - 2));
            chk("pp_occ", Occupancy, 3'd2);
        end
        WritebackREQ = 1'b0;
        set_in(1'b1, 16'h00C0, 6'h3F, 4'hF);
        step();
        set_in(1'b0, 16'h0, 6'h0, 4'h0);
        chk_head("pp_post", 1'b1, 16'h00B8, 6'h38, 4'h8, 3'd3);

        // flush drops same-cycle push and pop
        Flush = 1'b1;
        WritebackREQ = 1'b1;
        set_in(1'b1, 16'hDEAD, 6'h11, 4'h2);
        step();
        Flush = 1'b0;
        WritebackREQ = 1'b0;
        set_in(1'b0, 16'h0, 6'h0, 4'h0);
        chk_head("flush", 1'b0, 16'h0, 6'h0, 4'h0, 3'd0);
        chk("flush_ready", InReady, 1'b1);
        chk("flush_err", ErrorFlag, 1'b0);

        // clk_en low freezes everything
        clk_en = 1'b0;
        set_in(1'b1, 16'h5555, 6'h15, 4'h5);
        step();
        chk_head("frz_empty", 1'b0, 16'h0, 6'h0, 4'h0, 3'd0);
        clk_en = 1'b1;
        step();
        set_in(1'b1, 16'h6666, 6'h16, 4'h6);
        step();
        clk_en = 1'b0;
        Flush = 1'b1;
        WritebackREQ = 1'b1;
        set_in(1'b1, 16'h7777, 6'h17, 4'h7);
        step();
        step();
        chk_head("frz_hold", 1'b1, 16'h5555, 6'h15, 4'h5, 3'd2);
        chk("frz_err", ErrorFlag, 1'b0);

        // flush to empty, then request while empty
        clk_en = 1'b1;
        WritebackREQ = 1'b0;
        set_in(1'b0, 16'h0, 6'h0, 4'h0);
        step();
        Flush = 1'b0;
        WritebackREQ = 1'b1;
        step();
        WritebackREQ = 1'b0;
        chk("req_empty_occ", Occupancy, 3'd0);
        chk("req_empty_err", ErrorFlag, ERR_EXP);
        step();
        step();
        chk("err_sticky", ErrorFlag, ERR_EXP);

        // asynchronous reset mid-operation
        set_in(1'b1, 16'h8888, 6'h18, 4'h8);
        step();
        set_in(1'b0, 16'h0, 6'h0, 4'h0);
        chk("pre_rst_occ", Occupancy, 3'd1);
        #2;
        async_rst_n = 1'b0;
        #1;
        chk_head("async_rst", 1'b0, 16'h0, 6'h0, 4'h0, 3'd0);
        chk("async_rst_err", ErrorFlag, 1'b0);
        chk("async_rst_ready", InReady, 1'b1);
        step();
        async_rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
